// File: rtl/hdmi_cfg_sched.sv
// HDMI configuration scheduler: resets the MS7210, then walks the MS7200
// (rx) and MS7210 (tx) register tables, issuing one I2C write per entry.
// Entries with dev == 8'hFF are pauses of data*DLY_UNIT cycles. A NACKed
// write is retried up to MAX_RETRY times before the block parks in ERR.
// RST_HOLD and RST_WAIT are expected to be at least 1.
module hdmi_cfg_sched #(
  parameter int unsigned RST_HOLD   = 1000,
  parameter int unsigned RST_WAIT   = 1000,
  parameter int unsigned DLY_UNIT   = 1000,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned AUTO_START = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  output logic [7:0]  rx_tbl_addr,
  input  logic [31:0] rx_tbl_data,
  input  logic [7:0]  rx_tbl_len,
  output logic [7:0]  tx_tbl_addr,
  input  logic [31:0] tx_tbl_data,
  input  logic [7:0]  tx_tbl_len,
  output logic        iic_req,
  output logic [7:0]  iic_dev,
  output logic [15:0] iic_reg,
  output logic [7:0]  iic_wdata,
  input  logic        iic_done,
  input  logic        iic_nack,
  output logic        ms7210_rstn_out,
  output logic        rx_init_over,
  output logic        tx_init_over,
  output logic        busy,
  output logic        err
);

  typedef enum logic [3:0] {
    IDLE, RST_LO, RST_HI, FETCH, LOAD, WRITE, DELAY, NEXT, DONE, ERR
  } state_t;

  state_t      state;
  logic        ph;
  logic [8:0]  idx;
  logic [31:0] cnt;
  logic [31:0] retry;
  logic        auto_go;
  logic [31:0] tbl_data;
  logic [8:0]  tbl_len;
  logic [31:0] dly_cycles;

  // The active phase selects which table feeds the sequencer; the idle
  // table's address is parked at zero.
  assign tbl_data    = ph ? tx_tbl_data : rx_tbl_data;
  assign tbl_len     = {1'b0, (ph ? tx_tbl_len : rx_tbl_len)};
  assign rx_tbl_addr = (busy && !ph) ? idx[7:0] : 8'd0;
  assign tx_tbl_addr = (busy &&  ph) ? idx[7:0] : 8'd0;
  assign dly_cycles  = 32'(tbl_data[7:0]) * DLY_UNIT;
  assign busy        = !((state == IDLE) || (state == DONE) || (state == ERR));

  // Main sequencer: state, counters, I2C request fields and status flags.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state           <= IDLE;
      ph              <= 1'b0;
      idx             <= 9'd0;
      cnt             <= 32'd0;
      retry           <= 32'd0;
      auto_go         <= (AUTO_START != 0);
      iic_req         <= 1'b0;
      iic_dev         <= 8'd0;
      iic_reg         <= 16'd0;
      iic_wdata       <= 8'd0;
      ms7210_rstn_out <= 1'b0;
      rx_init_over    <= 1'b0;
      tx_init_over    <= 1'b0;
      err             <= 1'b0;
    end else begin
      auto_go <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start || auto_go) begin
            state           <= RST_LO;
            rx_init_over    <= 1'b0;
            tx_init_over    <= 1'b0;
            err             <= 1'b0;
            ph              <= 1'b0;
            idx             <= 9'd0;
            cnt             <= 32'd0;
            iic_req         <= 1'b0;
            ms7210_rstn_out <= 1'b0;
          end
        end
        RST_LO: begin
          if (cnt == RST_HOLD - 32'd1) begin
            cnt             <= 32'd0;
            ms7210_rstn_out <= 1'b1;
            state           <= RST_HI;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        RST_HI: begin
          if (cnt == RST_WAIT - 32'd1) begin
            cnt   <= 32'd0;
            idx   <= 9'd0;
            state <= FETCH;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        FETCH: begin
          retry <= 32'd0;
          if (idx >= tbl_len) begin
            state <= NEXT;
          end else begin
            state <= LOAD;
          end
        end
        LOAD: begin
          if (tbl_data[31:24] == 8'hFF) begin
            if (dly_cycles == 32'd0) begin
              idx   <= idx + 9'd1;
              state <= FETCH;
            end else begin
              cnt   <= dly_cycles - 32'd1;
              state <= DELAY;
            end
          end else begin
            iic_dev   <= tbl_data[31:24];
            iic_reg   <= tbl_data[23:8];
            iic_wdata <= tbl_data[7:0];
            iic_req   <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (iic_done) begin
            iic_req <= 1'b0;
            if (!iic_nack) begin
              idx   <= idx + 9'd1;
              state <= FETCH;
            end else if (retry < MAX_RETRY) begin
              retry <= retry + 32'd1;
              state <= LOAD;
            end else begin
              err   <= 1'b1;
              state <= ERR;
            end
          end
        end
        DELAY: begin
          if (cnt == 32'd0) begin
            idx   <= idx + 9'd1;
            state <= FETCH;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        NEXT: begin
          if (!ph) begin
            rx_init_over <= 1'b1;
            ph           <= 1'b1;
            idx          <= 9'd0;
            state        <= FETCH;
          end else begin
            tx_init_over <= 1'b1;
            state        <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_cfg_sched.sv
// Scoreboard bench for hdmi_cfg_sched: table ROMs and an I2C responder
// model; expected writes are queued by each scenario and popped per request.
module tb_hdmi_cfg_sched;

  localparam int HOLD = 4;
  localparam int WAIT = 4;
  localparam int DLY  = 2;
  localparam int NRET = 3;

  typedef struct {
    logic [31:0] f;
    logic        rx_over;
    int          gap;
  } exp_t;

  logic        sys_clk, sys_rst_n, start;
  logic [7:0]  rx_tbl_addr, tx_tbl_addr, rx_tbl_len, tx_tbl_len;
  logic [31:0] rx_tbl_data, tx_tbl_data;
  logic        iic_req, iic_done, iic_nack;
  logic [7:0]  iic_dev, iic_wdata;
  logic [15:0] iic_reg;
  logic        ms7210_rstn_out, rx_init_over, tx_init_over, busy, err;

  logic [31:0] rx_rom [256];
  logic [31:0] tx_rom [256];
  exp_t        exp_q[$];
  logic        nack_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          req_count = 0;
  int          cyc = 0;

  hdmi_cfg_sched #(
    .RST_HOLD(HOLD), .RST_WAIT(WAIT), .DLY_UNIT(DLY), .MAX_RETRY(NRET), .AUTO_START(1)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start),
    .rx_tbl_addr(rx_tbl_addr), .rx_tbl_data(rx_tbl_data), .rx_tbl_len(rx_tbl_len),
    .tx_tbl_addr(tx_tbl_addr), .tx_tbl_data(tx_tbl_data), .tx_tbl_len(tx_tbl_len),
    .iic_req(iic_req), .iic_dev(iic_dev), .iic_reg(iic_reg), .iic_wdata(iic_wdata),
    .iic_done(iic_done), .iic_nack(iic_nack), .ms7210_rstn_out(ms7210_rstn_out),
    .rx_init_over(rx_init_over), .tx_init_over(tx_init_over), .busy(busy), .err(err)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Cycle counter used for request spacing measurements.
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Synchronous table ROMs: data valid one cycle after the address.
  always @(posedge sys_clk) begin
    rx_tbl_data <= rx_rom[rx_tbl_addr];
    tx_tbl_data <= tx_rom[tx_tbl_addr];
  end

  // I2C master model: answers each request two cycles later, NACK taken
  // from nack_q (ACK when empty), and checks every request against exp_q.
  initial begin : responder
    int lat;
    int done_cyc;
    logic [31:0] cur;
    exp_t e;
    lat = -1; done_cyc = 0; cur = 32'd0;
    iic_done = 1'b0; iic_nack = 1'b0;
    forever begin
      @(negedge sys_clk);
      iic_done = 1'b0; iic_nack = 1'b0;
      if (!sys_rst_n) begin
        lat = -1;
      end else if (lat > 0) begin
        lat--;
        vectors++;
        if ({iic_req, iic_dev, iic_reg, iic_wdata} !== {1'b1, cur}) begin
          miscompares++;
          $display("[TB] FAIL req_stable: got %h required %h", {iic_req, iic_dev, iic_reg, iic_wdata}, {1'b1, cur});
        end
      end else if (lat == 0) begin
        iic_done = 1'b1;
        iic_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
        done_cyc = cyc;
        lat = -1;
      end else if (iic_req) begin
        req_count++;
        cur = {iic_dev, iic_reg, iic_wdata};
        lat = 2;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_req: got %h required none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.f) begin
            miscompares++;
            $display("[TB] FAIL req_fields: got %h required %h", cur, e.f);
          end
          vectors++;
          if (rx_init_over !== e.rx_over) begin
            miscompares++;
            $display("[TB] FAIL rx_over_at_req: got %b required %b", rx_init_over, e.rx_over);
          end
          if (e.gap >= 0) begin
            vectors++;
            if (cyc - done_cyc != e.gap) begin
              miscompares++;
              $display("[TB] FAIL req_gap: got %0d required %0d", cyc - done_cyc, e.gap);
            end
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] f, input logic rx_over, input int gap);
    exp_t e;
    e.f = f; e.rx_over = rx_over; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic load_basic_tables();
    rx_rom[0] = {8'h72, 16'h0010, 8'hA5};
    rx_rom[1] = {8'h72, 16'h1234, 8'h5A};
    tx_rom[0] = {8'hB2, 16'h00C0, 8'h3C};
    rx_tbl_len = 8'd2; tx_tbl_len = 8'd1;
    push_exp(rx_rom[0], 1'b0, -1);
    push_exp(rx_rom[1], 1'b0, 3);
    push_exp(tx_rom[0], 1'b1, -1);
  endtask

  // Waits for the sequence to settle in DONE/ERR, counting cycles spent
  // busy with the MS7210 reset low; start is released on the first edge.
  task automatic wait_end(output int low);
    int n;
    bit fin;
    low = 0; n = 0; fin = 1'b0;
    while (!fin && n < 3000) begin
      @(negedge sys_clk);
      start = 1'b0;
      n++;
      if (busy && !ms7210_rstn_out) low++;
      if (!busy && (tx_init_over || err)) fin = 1'b1;
    end
    vectors++;
    if (!fin) begin
      miscompares++;
      $display("[TB] FAIL seq_timeout: finished %0b required 1", fin);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b1; start = 1'b0;
    for (int i = 0; i < 256; i++) begin rx_rom[i] = 32'd0; tx_rom[i] = 32'd0; end
    load_basic_tables();
    #3 sys_rst_n = 1'b0;
    #1;
    vectors++;
    if ({iic_req, iic_dev, iic_reg, iic_wdata} !== 33'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_iic: got %h required 0", {iic_req, iic_dev, iic_reg, iic_wdata});
    end
    vectors++;
    if ({rx_tbl_addr, tx_tbl_addr} !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_addr: got %h required 0", {rx_tbl_addr, tx_tbl_addr});
    end
    vectors++;
    if ({rx_init_over, tx_init_over, busy, err, ms7210_rstn_out} !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_status: got %b required 00000", {rx_init_over, tx_init_over, busy, err, ms7210_rstn_out});
    end
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int low;
    req_count = 0;
    wait_end(low);
    vectors++;
    if (low != HOLD) begin miscompares++; $display("[TB] FAIL basic_rstn_low: got %0d required %0d", low, HOLD); end
    vectors++;
    if (req_count != 3) begin miscompares++; $display("[TB] FAIL basic_req_count: got %0d required 3", req_count); end
    vectors++;
    if ({rx_init_over, tx_init_over, busy, err, ms7210_rstn_out} !== 5'b11001) begin
      miscompares++;
      $display("[TB] FAIL basic_status: got %b required 11001", {rx_init_over, tx_init_over, busy, err, ms7210_rstn_out});
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("[TB] FAIL basic_leftover: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_retry();
    int low;
    exp_q.delete(); nack_q.delete(); req_count = 0;
    rx_rom[0] = {8'h72, 16'h0100, 8'h11};
    rx_rom[1] = {8'h72, 16'h0101, 8'h22};
    tx_rom[0] = {8'hB2, 16'h0200, 8'h33};
    rx_tbl_len = 8'd2; tx_tbl_len = 8'd1;
    nack_q.push_back(1'b1); nack_q.push_back(1'b1);
    push_exp(rx_rom[0], 1'b0, -1);
    push_exp(rx_rom[0], 1'b0, 2);
    push_exp(rx_rom[0], 1'b0, 2);
    push_exp(rx_rom[1], 1'b0, 3);
    push_exp(tx_rom[0], 1'b1, -1);
    start = 1'b1;
    wait_end(low);
    vectors++;
    if (req_count != 5) begin miscompares++; $display("[TB] FAIL retry_req_count: got %0d required 5", req_count); end
    vectors++;
    if ({rx_init_over, tx_init_over, err} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL retry_status: got %b required 110", {rx_init_over, tx_init_over, err});
    end
  endtask

  task automatic test_persistent_nack();
    int low;
    exp_q.delete(); nack_q.delete(); req_count = 0;
    rx_rom[0] = {8'h72, 16'h0300, 8'h44};
    tx_rom[0] = {8'hB2, 16'h0301, 8'h55};
    rx_tbl_len = 8'd1; tx_tbl_len = 8'd1;
    nack_q.push_back(1'b0);
    for (int i = 0; i <= NRET; i++) nack_q.push_back(1'b1);
    push_exp(rx_rom[0], 1'b0, -1);
    push_exp(tx_rom[0], 1'b1, -1);
    for (int i = 0; i < NRET; i++) push_exp(tx_rom[0], 1'b1, 2);
    start = 1'b1;
    wait_end(low);
    repeat (3) @(negedge sys_clk);
    vectors++;
    if (req_count != NRET + 2) begin miscompares++; $display("[TB] FAIL nack_req_count: got %0d required %0d", req_count, NRET + 2); end
    vectors++;
    if ({err, rx_init_over, tx_init_over, busy, iic_req} !== 5'b11000) begin
      miscompares++;
      $display("[TB] FAIL nack_status: got %b required 11000", {err, rx_init_over, tx_init_over, busy, iic_req});
    end
  endtask

  task automatic test_delay();
    int low;
    exp_q.delete(); nack_q.delete(); req_count = 0;
    rx_rom[0] = {8'h72, 16'h0020, 8'h11};
    rx_rom[1] = {8'hFF, 16'h0000, 8'h03};
    rx_rom[2] = {8'h72, 16'h0021, 8'h22};
    tx_rom[0] = {8'hB2, 16'h0030, 8'h33};
    tx_rom[1] = {8'hFF, 16'h0000, 8'h00};
    tx_rom[2] = {8'hB2, 16'h0031, 8'h44};
    rx_tbl_len = 8'd3; tx_tbl_len = 8'd3;
    push_exp(rx_rom[0], 1'b0, -1);
    push_exp(rx_rom[2], 1'b0, 3 + 2 + 3 * DLY);
    push_exp(tx_rom[0], 1'b1, -1);
    push_exp(tx_rom[2], 1'b1, 3 + 2);
    start = 1'b1;
    wait_end(low);
    vectors++;
    if (req_count != 4) begin miscompares++; $display("[TB] FAIL delay_req_count: got %0d required 4", req_count); end
    vectors++;
    if ({rx_init_over, tx_init_over, err} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL delay_status: got %b required 110", {rx_init_over, tx_init_over, err});
    end
  endtask

  task automatic test_empty_rx_and_start();
    int low;
    int k;
    exp_q.delete(); nack_q.delete(); req_count = 0;
    tx_rom[0] = {8'hB2, 16'h0400, 8'h66};
    rx_tbl_len = 8'd0; tx_tbl_len = 8'd1;
    push_exp(tx_rom[0], 1'b1, -1);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    k = 0;
    while (!iic_req && k < 500) begin @(negedge sys_clk); k++; end
    vectors++;
    if (!iic_req) begin miscompares++; $display("[TB] FAIL empty_req_seen: got %b required 1", iic_req); end
    start = 1'b1;
    wait_end(low);
    vectors++;
    if (low != 0) begin miscompares++; $display("[TB] FAIL busy_start_restart: got %0d required 0", low); end
    vectors++;
    if (req_count != 1) begin miscompares++; $display("[TB] FAIL empty_req_count: got %0d required 1", req_count); end
    vectors++;
    if ({rx_init_over, tx_init_over, busy, err} !== 4'b1100) begin
      miscompares++;
      $display("[TB] FAIL empty_status: got %b required 1100", {rx_init_over, tx_init_over, busy, err});
    end
  endtask

  task automatic test_reset_mid_write();
    int low;
    int k;
    exp_q.delete(); nack_q.delete(); req_count = 0;
    for (int i = 0; i < 256; i++) begin rx_rom[i] = 32'd0; tx_rom[i] = 32'd0; end
    load_basic_tables();
    start = 1'b1;
    k = 0;
    do begin @(negedge sys_clk); start = 1'b0; k++; end while (!iic_req && k < 500);
    #2 sys_rst_n = 1'b0;
    #1;
    vectors++;
    if ({iic_req, iic_dev, iic_reg, iic_wdata, rx_tbl_addr, tx_tbl_addr,
         rx_init_over, tx_init_over, busy, err, ms7210_rstn_out} !== 54'd0) begin
      miscompares++;
      $display("[TB] FAIL midwrite_reset: got %h required 0", {iic_req, iic_dev, iic_reg, iic_wdata, rx_tbl_addr,
               tx_tbl_addr, rx_init_over, tx_init_over, busy, err, ms7210_rstn_out});
    end
    exp_q.delete(); nack_q.delete(); req_count = 0;
    load_basic_tables();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_end(low);
    vectors++;
    if (low != HOLD) begin miscompares++; $display("[TB] FAIL restart_rstn_low: got %0d required %0d", low, HOLD); end
    vectors++;
    if (req_count != 3) begin miscompares++; $display("[TB] FAIL restart_req_count: got %0d required 3", req_count); end
    vectors++;
    if ({rx_init_over, tx_init_over, busy, err} !== 4'b1100) begin
      miscompares++;
      $display("[TB] FAIL restart_status: got %b required 1100", {rx_init_over, tx_init_over, busy, err});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_retry();
    test_persistent_nack();
    test_delay();
    test_empty_rx_and_start();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
